// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that serialises per-requester JK commands onto a shared
// bank of state bits; one command is executed every two cycles at most.
module jk_bank_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int NBITS = 8,
    parameter  int IDXW  = 3,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [IDXW*NREQ-1:0] idx,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic                 err,
    output logic                 busy,
    output logic [NBITS-1:0]     q_bank
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    win_q;
    logic [1:0]        op_q;
    logic [IDXW-1:0]   idx_q;
    logic [NREQ-1:0]   gnt_q;
    logic              done_q;
    logic [IDW-1:0]    done_id_q;
    logic              err_q;
    logic              busy_q;
    logic [NBITS-1:0]  bank_q;

    logic [NREQ-1:0]   rot_s;
    logic              any_s;
    logic              hit_s;
    logic [IDW-1:0]    win_s;
    int                cand_s;
    logic [1:0]        op_a  [NREQ];
    logic [IDXW-1:0]   idx_a [NREQ];
    logic [NBITS-1:0]  bank_d;
    logic              err_s;
    logic [IDW-1:0]    ptr_d;

    // Split the flat command buses into per-requester fields.
    always_comb begin
        for (int r = 0; r < NREQ; r++) begin
            op_a[r]  = op[2*r +: 2];
            idx_a[r] = idx[IDXW*r +: IDXW];
        end
    end

    // Rotate requests so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        rot_s  = NREQ'({req, req} >> ptr_q);
        any_s  = 1'b0;
        hit_s  = 1'b0;
        win_s  = '0;
        cand_s = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = int'(ptr_q) + k;
            cand_s = (cand_s >= NREQ) ? (cand_s - NREQ) : cand_s;
            hit_s  = rot_s[k] & ~any_s;
            win_s  = hit_s ? IDW'(cand_s) : win_s;
            any_s  = any_s | hit_s;
        end
    end

    // JK update of the addressed bit; out-of-range targets leave the bank alone.
    always_comb begin
        bank_d = bank_q;
        err_s  = (int'(idx_q) >= NBITS);
        if (!err_s) begin
            case (op_q)
                2'b01:   bank_d[idx_q] = 1'b0;
                2'b10:   bank_d[idx_q] = 1'b1;
                2'b11:   bank_d[idx_q] = ~bank_q[idx_q];
                default: bank_d[idx_q] = bank_q[idx_q];
            endcase
        end else begin
            bank_d = bank_q;
        end
        ptr_d = (win_q == IDW'(NREQ - 1)) ? '0 : (win_q + IDW'(1));
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            op_q      <= 2'b00;
            idx_q     <= '0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            bank_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (any_s) begin
                        win_q   <= win_s;
                        op_q    <= op_a[win_s];
                        idx_q   <= idx_a[win_s];
                        gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win_s;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end else begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    bank_q    <= bank_d;
                    gnt_q     <= '0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    done_id_q <= win_q;
                    err_q     <= err_s;
                    ptr_q     <= ptr_d;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign q_bank  = bank_q;

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Shared controller for a bank of NBITS JK-style state bits.
- Up to NREQ requesters each issue one JK command (hold/clear/set/toggle) aimed at one bit index.
- Round-robin arbitration serialises the commands; the winning command is applied to the bank.
- Used wherever several control agents must update a common flag register with JK semantics without collisions.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 8, number of JK state bits in the bank.
- IDXW, 3, width of each requester's bit-index field.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  NREQ  per-requester request, level.
- op  input  2*NREQ  per-requester command {j,k}; requester r uses bits [2r+1:2r].
- idx  input  IDXW*NREQ  per-requester target bit; requester r uses bits [IDXW*r+IDXW-1:IDXW*r].
- gnt  output  NREQ  one-hot grant, registered.
- done  output  1  one-cycle pulse; command applied.
- done_id  output  $clog2(NREQ)  requester index of the completed command; valid while done=1.
- err  output  1  one-cycle pulse with done when the latched idx >= NBITS.
- busy  output  1  high in EXEC state.
- q_bank  output  NBITS  current bank state, registered.

Behaviour:
- Reset: rst_n=0 at a rising edge clears the following: q_bank=0, gnt=0, done=0, done_id=0, err=0, busy=0, rr pointer=0, state=IDLE. Reset during EXEC abandons the command: no bank update, no done.
- FSM states: IDLE, EXEC.
- IDLE:
  - If any req bit is set at the edge: pick the winner, latch its op and idx, set gnt to one-hot(winner), busy=1, go to EXEC.
  - Otherwise stay in IDLE, gnt=0.
- Winner selection: scan requesters ptr, ptr+1, ... mod NREQ; the first one with req=1 wins.
- EXEC lasts exactly one cycle; gnt and busy are high during it. No arbitration occurs in EXEC. At the edge ending EXEC:
  - Apply latched op to q_bank[idx]: 00 hold, 01 clear to 0, 10 set to 1, 11 invert.
  - gnt=0, busy=0.
  - done=1, done_id=winner.
  - err=1 if idx>=NBITS; the bank is then unchanged.
  - ptr=(winner+1) mod NREQ.
  - Go to IDLE.
- done, err and the new q_bank value are all visible in the same cycle, which is the IDLE cycle following EXEC. done and err drop after one cycle.
- Latency: req seen at edge N produces gnt high in cycle N..N+1 and done high with q_bank updated after edge N+1. Throughput is at most one command per 2 cycles. Back-to-back commands are allowed: IDLE arbitrates during the cycle in which done is high.
- Requester handshake:
  - Hold req, op and idx stable until gnt is sampled high.
  - Drop req at the same edge at which gnt is sampled high.
  - If req is still high in the following IDLE cycle, it counts as a new request.
- op and idx are sampled only at the IDLE→EXEC edge; changes after that are ignored.
- The pointer advances only after a completed command. Idle cycles and reset-abandoned commands do not advance it.
- Only one bank bit changes per command. Bits not addressed always hold their value.
- Out-of-range idx (possible only when NBITS<2**IDXW) is harmless: done and err pulse, bank unchanged.

Test Plan:
- Reset: drive garbage req/op/idx with rst_n=0 for 3 edges -> q_bank=0, gnt=0, done=0, busy=0. Release reset with req=0 -> outputs stay 0.
- Basic ops, requester 0 only, idx=2, sequence 10,11,11,01,00 -> q_bank[2] goes 1,0,1,0,0. Each done is 2 cycles after its req edge with done_id=0; other bits stay 0.
- Round robin: req=4'b1111 held, each requester drops req on its grant -> grant order 0,1,2,3. Then re-raise req=4'b1001 -> order 0,3.
- Fairness: requesters 1 and 2 re-request continuously, op=10 on idx 1 and idx 2 -> grants alternate 1,2,1,2; neither is starved over 20 commands.
- Out of range with NBITS=6 override: requester 2 sends op=10, idx=7 -> done=1, err=1, done_id=2, q_bank unchanged.
- Mid-operation reset: requester 1 granted (EXEC), rst_n=0 at the EXEC-ending edge -> no done, q_bank=0, ptr=0. Next req=4'b0011 grants requester 0 first.
